// File: rtl/dmem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_ctrl_if
// Description : Core-side request/response signals and external data-bus
//               signals of the data-memory bus controller, bundled together.
//               master = controller view, slave = core + bus device view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_bus_ctrl_if;
  // Core (MEM stage) side
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [1:0]  core_size;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;
  // External data bus side
  logic [31:0] DAD;
  logic [31:0] DDT_out;
  logic        DDT_oe;
  logic [31:0] DDT_in;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  modport master (
    input  core_req, core_we, core_addr, core_wdata, core_size,
    input  DDT_in, ACKD_n,
    output core_rdata, core_stall, core_err,
    output DAD, DDT_out, DDT_oe, MREQ, WRITE, SIZE
  );

  modport slave (
    output core_req, core_we, core_addr, core_wdata, core_size,
    output DDT_in, ACKD_n,
    input  core_rdata, core_stall, core_err,
    input  DAD, DDT_out, DDT_oe, MREQ, WRITE, SIZE
  );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Data-memory bus controller. Turns one MEM-stage load/store
//               into one handshaked bus cycle, stalls the pipeline until the
//               bus acknowledges, and flags misaligned requests and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_bus_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_size;
  logic             r_we;
  logic [31:0]      r_rdata;
  logic             w_illegal;
  logic             w_latch;
  logic             w_capture;
  logic [31:0]      w_lanes;

  // Alignment/size legality of the request currently presented by the core
  always_comb begin
    w_illegal = 1'b0;
    case (bus.core_size)
      2'b00:   w_illegal = 1'b0;
      2'b01:   w_illegal = bus.core_addr[0];
      2'b10:   w_illegal = (bus.core_addr[1:0] != 2'b00);
      default: w_illegal = 1'b1;
    endcase
  end

  // Store data replicated across byte lanes so any lane select sees the data
  always_comb begin
    w_lanes = r_wdata;
    case (r_size)
      2'b00:   w_lanes = {4{r_wdata[7:0]}};
      2'b01:   w_lanes = {2{r_wdata[15:0]}};
      default: w_lanes = r_wdata;
    endcase
  end

  // Next-state, wait counter and latch/capture strobes
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.core_req) begin
          if (w_illegal) begin
            w_next = ERR;
          end else begin
            w_next     = REQ;
            w_latch    = 1'b1;
            w_cnt_next = '0;
          end
        end
      end
      REQ: begin
        if (!bus.ACKD_n) begin
          // Acknowledge wins over a timeout expiring on the same edge
          w_next     = DONE;
          w_capture  = !r_we;
          w_cnt_next = '0;
        end else if (r_cnt == C_LAST) begin
          w_next     = ERR;
          w_cnt_next = '0;
        end else if (r_cnt != C_MAX) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, counter, request latch and read-data capture registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr  <= bus.core_addr;
        r_wdata <= bus.core_wdata;
        r_size  <= bus.core_size;
        r_we    <= bus.core_we;
      end
      if (w_capture) begin
        r_rdata <= bus.DDT_in;
      end
    end
  end

  // Output decode; bus signals only come from latched registers during REQ
  always_comb begin
    bus.core_stall = 1'b0;
    bus.core_err   = 1'b0;
    bus.core_rdata = r_rdata;
    bus.MREQ       = 1'b0;
    bus.DAD        = '0;
    bus.WRITE      = 1'b0;
    bus.SIZE       = 2'b00;
    bus.DDT_oe     = 1'b0;
    bus.DDT_out    = '0;
    case (r_state)
      IDLE: bus.core_stall = bus.core_req;
      REQ: begin
        bus.core_stall = 1'b1;
        bus.MREQ       = 1'b1;
        bus.DAD        = r_addr;
        bus.WRITE      = r_we;
        bus.SIZE       = r_size;
        bus.DDT_oe     = r_we;
        bus.DDT_out    = r_we ? w_lanes : 32'h0;
      end
      ERR: begin
        bus.core_err   = 1'b1;
        bus.core_rdata = '0;
      end
      default: bus.core_stall = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Self-checking bench for dmem_bus_ctrl. Each transaction task
//               drives the core/bus inputs cycle by cycle and publishes the
//               outputs the bus protocol demands for that cycle; a single
//               negedge process compares them with the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_bus_ctrl_if bus_if ();

  dmem_bus_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  typedef struct packed {
    logic        stall;
    logic        err;
    logic        mreq;
    logic        write;
    logic        oe;
    logic [1:0]  size;
    logic [31:0] dad;
    logic [31:0] ddt;
    logic [31:0] rdata;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        ex;
  bit          chk_en = 1'b0;
  logic [31:0] m_rdata;      // last word returned by a completed load
  int          n_stall;      // cycles with core_stall high in last txn
  int          n_mreq;       // cycles with MREQ high in last txn
  logic [31:0] last_ddt;     // DDT_out seen on first bus cycle of last txn

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Compare every cycle once outputs have settled, mid-way between edges
  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_stall", 32'(bus_if.core_stall), 32'(ex.stall));
      chk("core_err",   32'(bus_if.core_err),   32'(ex.err));
      chk("MREQ",       32'(bus_if.MREQ),       32'(ex.mreq));
      chk("DDT_oe",     32'(bus_if.DDT_oe),     32'(ex.oe));
      chk("core_rdata", bus_if.core_rdata,      ex.rdata);
      if (ex.mreq) begin
        chk("DAD",   bus_if.DAD,           ex.dad);
        chk("WRITE", 32'(bus_if.WRITE),    32'(ex.write));
        chk("SIZE",  32'(bus_if.SIZE),     32'(ex.size));
      end
      if (ex.oe) chk("DDT_out", bus_if.DDT_out, ex.ddt);
    end
  end

  function automatic exp_t quiet(input logic [31:0] rd);
    exp_t e;
    e = '0;
    e.rdata = rd;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
    if (bus_if.core_stall) n_stall++;
    if (bus_if.MREQ) n_mreq++;
  endtask

  task automatic idle(input logic ack_n);
    step();
    bus_if.core_req = 1'b0;
    bus_if.ACKD_n   = ack_n;
    ex = quiet(m_rdata);
  endtask

  // One core request. waits < 0 means the bus never acknowledges.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input int waits, input logic [31:0] word,
                     input bit hold);
    bit          legal;
    int          nreq;
    logic [31:0] lane;
    legal = !(size == 2'b11 || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00));
    lane  = (size == 2'b00) ? wdata[7:0] * 32'h01010101 :
            (size == 2'b01) ? wdata[15:0] * 32'h00010001 : wdata;
    n_stall = 0;
    n_mreq  = 0;
    // Request cycle: controller idle, stall follows core_req immediately
    step();
    bus_if.core_req   = 1'b1;
    bus_if.core_we    = we;
    bus_if.core_addr  = addr;
    bus_if.core_wdata = wdata;
    bus_if.core_size  = size;
    bus_if.ACKD_n     = 1'b1;
    bus_if.DDT_in     = 32'h0BAD0BAD;
    ex = quiet(m_rdata);
    ex.stall = 1'b1;
    sample();
    if (!legal) begin
      step();
      bus_if.core_req = hold;
      ex = quiet(32'h0);
      ex.err = 1'b1;
      sample();
      return;
    end
    nreq = (waits < 0) ? TO : waits + 1;
    for (int i = 0; i < nreq; i++) begin
      step();
      // Scramble the core inputs: the bus must show the latched request
      bus_if.core_we    = ~we;
      bus_if.core_addr  = ~addr;
      bus_if.core_wdata = ~wdata;
      bus_if.core_size  = ~size;
      if (waits >= 0 && i == nreq - 1) begin
        bus_if.ACKD_n = 1'b0;
        bus_if.DDT_in = word;
      end else begin
        bus_if.ACKD_n = 1'b1;
        bus_if.DDT_in = 32'h0BAD0BAD;
      end
      ex = quiet(m_rdata);
      ex.stall = 1'b1;
      ex.mreq  = 1'b1;
      ex.write = we;
      ex.oe    = we;
      ex.size  = size;
      ex.dad   = addr;
      ex.ddt   = lane;
      sample();
      if (i == 0) last_ddt = bus_if.DDT_out;
    end
    // Completion cycle; ACKD_n is left as driven (a held-low ack is ignored)
    step();
    bus_if.core_req = hold;
    bus_if.DDT_in   = 32'h0BAD0BAD;
    if (waits < 0) begin
      ex = quiet(32'h0);
      ex.err = 1'b1;
    end else begin
      if (!we) m_rdata = word;
      ex = quiet(m_rdata);
    end
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b0;
    bus_if.core_req   = 1'b0;
    bus_if.core_we    = 1'b0;
    bus_if.core_addr  = '0;
    bus_if.core_wdata = '0;
    bus_if.core_size  = 2'b00;
    bus_if.DDT_in     = '0;
    bus_if.ACKD_n     = 1'b1;
    m_rdata           = '0;
    ex                = '0;
    repeat (3) step();
    rst    = 1'b1;
    ex     = quiet(32'h0);
    chk_en = 1'b1;
    idle(1'b1);
    idle(1'b0);   // ack while idle and without request: nothing happens

    // Zero-wait word load
    txn(1'b0, 32'h100, 32'h0, 2'b10, 0, 32'hDEADBEEF, 1'b0);
    chk("lit_load_rdata", bus_if.core_rdata, 32'hDEADBEEF);
    chk("lit_load_stall_cycles", 32'(n_stall), 32'd2);
    chk("lit_load_mreq_cycles", 32'(n_mreq), 32'd1);
    idle(1'b1);

    // Byte store with 3 wait states
    txn(1'b1, 32'h203, 32'h000000A5, 2'b00, 3, 32'h0, 1'b0);
    chk("lit_byte_lanes", last_ddt, 32'hA5A5A5A5);
    chk("lit_store_stall_cycles", 32'(n_stall), 32'd5);
    chk("lit_store_mreq_cycles", 32'(n_mreq), 32'd4);
    idle(1'b1);

    // Half and word stores
    txn(1'b1, 32'h202, 32'h1234BEEF, 2'b01, 1, 32'h0, 1'b0);
    chk("lit_half_lanes", last_ddt, 32'hBEEFBEEF);
    txn(1'b1, 32'h204, 32'hCAFEF00D, 2'b10, 0, 32'h0, 1'b0);
    idle(1'b1);

    // Misaligned word, misaligned half, reserved size
    txn(1'b0, 32'h102, 32'h0, 2'b10, 0, 32'h0, 1'b0);
    chk("lit_misal_word_stall", 32'(n_stall), 32'd1);
    chk("lit_misal_word_mreq", 32'(n_mreq), 32'd0);
    txn(1'b1, 32'h101, 32'h77, 2'b01, 0, 32'h0, 1'b0);
    chk("lit_misal_half_mreq", 32'(n_mreq), 32'd0);
    txn(1'b0, 32'h100, 32'h0, 2'b11, 0, 32'h0, 1'b0);
    idle(1'b1);

    // Timeout, then a late acknowledge while idle
    txn(1'b0, 32'h300, 32'h0, 2'b10, -1, 32'h0, 1'b0);
    chk("lit_timeout_mreq_cycles", 32'(n_mreq), 32'(TO));
    idle(1'b0);
    idle(1'b1);

    // Acknowledge on the last cycle before the timeout would fire
    txn(1'b0, 32'h304, 32'h0, 2'b10, TO - 1, 32'h0F1E2D3C, 1'b0);
    chk("lit_late_ack_rdata", bus_if.core_rdata, 32'h0F1E2D3C);
    idle(1'b1);

    // Back-to-back load then store with core_req held high
    txn(1'b0, 32'h400, 32'h0, 2'b10, 0, 32'h11223344, 1'b1);
    txn(1'b1, 32'h404, 32'h55667788, 2'b10, 1, 32'h0, 1'b0);
    idle(1'b1);

    // Reset in the middle of a bus cycle
    step();
    bus_if.core_req  = 1'b1;
    bus_if.core_we   = 1'b0;
    bus_if.core_addr = 32'h500;
    bus_if.core_size = 2'b10;
    bus_if.ACKD_n    = 1'b1;
    ex = quiet(m_rdata);
    ex.stall = 1'b1;
    step();
    ex = quiet(m_rdata);
    ex.stall = 1'b1;
    ex.mreq  = 1'b1;
    ex.dad   = 32'h500;
    ex.size  = 2'b10;
    step();
    rst             = 1'b0;
    bus_if.core_req = 1'b0;
    step();
    rst     = 1'b1;
    m_rdata = 32'h0;
    ex      = quiet(m_rdata);
    #2;
    chk("lit_reset_mreq", 32'(bus_if.MREQ), 32'd0);
    chk("lit_reset_rdata", bus_if.core_rdata, 32'h0);
    idle(1'b1);

    // Recovery after reset
    txn(1'b0, 32'h600, 32'h0, 2'b01, 2, 32'hA1B2C3D4, 1'b0);
    idle(1'b1);
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
